// File: rtl/fwd_hazard_ctrl_pkg.sv
// Core control package: forwarding-select encodings, the shadow-pipeline stage
// tag record, and the default register-index width.
package fwd_hazard_ctrl_pkg;

  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              uses_rs1;
    logic              uses_rs2;
    logic              regwrite;
    logic              memread;
  } stage_tag_t;

  localparam stage_tag_t TAG_BUBBLE = '0;

  function automatic logic writes_reg(input stage_tag_t t);
    return t.regwrite && (t.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage request and pipeline-control response bundle between the decode
// stage and the forwarding/hazard controller.
interface fwd_hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
);

  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs1_i;
  logic [REG_AW-1:0] id_rs2_i;
  logic [REG_AW-1:0] id_rd_i;
  logic              id_uses_rs1_i;
  logic              id_uses_rs2_i;
  logic              id_regwrite_i;
  logic              id_memread_i;
  logic              flush_i;

  logic              stall_o;
  logic              bubble_o;
  logic [1:0]        fwd_a_o;
  logic [1:0]        fwd_b_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_rd_i,
    output id_uses_rs1_i, id_uses_rs2_i, id_regwrite_i, id_memread_i,
    output flush_i,
    input  stall_o, bubble_o, fwd_a_o, fwd_b_o, stall_cnt_o
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_rd_i,
    input  id_uses_rs1_i, id_uses_rs2_i, id_regwrite_i, id_memread_i,
    input  flush_i,
    output stall_o, bubble_o, fwd_a_o, fwd_b_o, stall_cnt_o
  );

endinterface

// File: rtl/fwd_hazard_ctrl_fwd_sel_cmp.sv
// Operand forwarding select for one EX source: youngest in-flight producer
// (MEM before WB) wins, x0 never forwards.
module fwd_sel_cmp #(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0]             ex_rs_i,
  input  logic                          ex_uses_i,
  input  logic [REG_AW-1:0]             mem_rd_i,
  input  logic                          mem_regwrite_i,
  input  logic [REG_AW-1:0]             wb_rd_i,
  input  logic                          wb_regwrite_i,
  output fwd_hazard_ctrl_pkg::fwd_sel_e sel_o
);

  import fwd_hazard_ctrl_pkg::*;

  logic mem_hit;
  logic wb_hit;

  always_comb begin
    mem_hit = ex_uses_i && mem_regwrite_i && (mem_rd_i != '0) && (mem_rd_i == ex_rs_i);
    wb_hit  = ex_uses_i && wb_regwrite_i  && (wb_rd_i  != '0) && (wb_rd_i  == ex_rs_i);
    sel_o   = FWD_RF;
    if (mem_hit) begin
      sel_o = FWD_MEM;
    end else if (wb_hit) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller beside ID: shadows EX/MEM/WB
// register tags, drives forwarding selects, stall/bubble, and a stall counter.
module fwd_hazard_ctrl #(
  parameter int unsigned REG_AW = fwd_hazard_ctrl_pkg::REG_AW,
  parameter int unsigned CNT_W  = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  fwd_hazard_ctrl_if.slave   bus
);

  import fwd_hazard_ctrl_pkg::*;

  if (REG_AW != fwd_hazard_ctrl_pkg::REG_AW) begin : g_bad_reg_aw
    $error("fwd_hazard_ctrl: REG_AW must match the stage tag width in fwd_hazard_ctrl_pkg");
  end

  stage_tag_t       ex_q, ex_d;
  stage_tag_t       mem_q, mem_d;
  stage_tag_t       wb_q, wb_d;
  stage_tag_t       id_tag;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             hz;
  logic             bubble;
  logic             rs1_hit;
  logic             rs2_hit;
  fwd_sel_e         sel_a;
  fwd_sel_e         sel_b;

  always_comb begin
    id_tag          = TAG_BUBBLE;
    id_tag.rs1      = bus.id_rs1_i;
    id_tag.rs2      = bus.id_rs2_i;
    id_tag.rd       = bus.id_rd_i;
    id_tag.uses_rs1 = bus.id_uses_rs1_i;
    id_tag.uses_rs2 = bus.id_uses_rs2_i;
    id_tag.regwrite = bus.id_regwrite_i;
    id_tag.memread  = bus.id_memread_i;
  end

  // Flush outranks the hazard: a squashed ID instruction never stalls.
  always_comb begin
    rs1_hit = bus.id_uses_rs1_i && (bus.id_rs1_i == ex_q.rd);
    rs2_hit = bus.id_uses_rs2_i && (bus.id_rs2_i == ex_q.rd);
    hz      = bus.id_valid_i && !bus.flush_i && ex_q.memread && (ex_q.rd != '0)
              && (rs1_hit || rs2_hit);
    bubble  = hz || bus.flush_i || !bus.id_valid_i;
  end

  always_comb begin
    ex_d        = bubble ? TAG_BUBBLE : id_tag;
    mem_d       = ex_q;
    wb_d        = mem_q;
    stall_cnt_d = stall_cnt_q;
    if (hz && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_q        <= TAG_BUBBLE;
      mem_q       <= TAG_BUBBLE;
      wb_q        <= TAG_BUBBLE;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  fwd_sel_cmp #(.REG_AW(REG_AW)) u_fwd_a (
    .ex_rs_i        (ex_q.rs1),
    .ex_uses_i      (ex_q.uses_rs1),
    .mem_rd_i       (mem_q.rd),
    .mem_regwrite_i (mem_q.regwrite),
    .wb_rd_i        (wb_q.rd),
    .wb_regwrite_i  (wb_q.regwrite),
    .sel_o          (sel_a)
  );

  fwd_sel_cmp #(.REG_AW(REG_AW)) u_fwd_b (
    .ex_rs_i        (ex_q.rs2),
    .ex_uses_i      (ex_q.uses_rs2),
    .mem_rd_i       (mem_q.rd),
    .mem_regwrite_i (mem_q.regwrite),
    .wb_rd_i        (wb_q.rd),
    .wb_regwrite_i  (wb_q.regwrite),
    .sel_o          (sel_b)
  );

  assign bus.stall_o     = hz;
  assign bus.bubble_o    = bubble;
  assign bus.fwd_a_o     = sel_a;
  assign bus.fwd_b_o     = sel_b;
  assign bus.stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: per-cycle instruction vectors with
// hand-derived expectations, plus reset and counter-saturation sequences.
module tb_fwd_hazard_ctrl;

  logic clk;
  logic rst;

  fwd_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) bus ();
  fwd_hazard_ctrl_if #(.REG_AW(5), .CNT_W(2))  bus2 ();

  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(2)) dut2 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        u1;
    logic        u2;
    logic        rw;
    logic        mr;
    logic        fl;
    logic        stall;
    logic        bub;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] cnt;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  vec_t sbq[$];

  function automatic vec_t mk(input logic v, input int rs1, input int rs2, input int rd,
                              input logic u1, input logic u2, input logic rw, input logic mr,
                              input logic fl, input logic st, input logic bb,
                              input logic [1:0] fa, input logic [1:0] fb, input int cnt);
    vec_t r;
    r.valid = v;   r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.rd = 5'(rd);
    r.u1 = u1;     r.u2 = u2;       r.rw = rw;       r.mr = mr;  r.fl = fl;
    r.stall = st;  r.bub = bb;      r.fa = fa;       r.fb = fb;  r.cnt = 16'(cnt);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive1(input vec_t v);
    bus.id_valid_i    = v.valid;
    bus.id_rs1_i      = v.rs1;
    bus.id_rs2_i      = v.rs2;
    bus.id_rd_i       = v.rd;
    bus.id_uses_rs1_i = v.u1;
    bus.id_uses_rs2_i = v.u2;
    bus.id_regwrite_i = v.rw;
    bus.id_memread_i  = v.mr;
    bus.flush_i       = v.fl;
  endtask

  task automatic drive2(input vec_t v);
    bus2.id_valid_i    = v.valid;
    bus2.id_rs1_i      = v.rs1;
    bus2.id_rs2_i      = v.rs2;
    bus2.id_rd_i       = v.rd;
    bus2.id_uses_rs1_i = v.u1;
    bus2.id_uses_rs2_i = v.u2;
    bus2.id_regwrite_i = v.rw;
    bus2.id_memread_i  = v.mr;
    bus2.flush_i       = v.fl;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t nop;
    vec_t e;
    vec_t lw4;
    vec_t use4;
    nop  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0);
    lw4  = mk(1, 1, 0, 4, 1, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0);
    use4 = mk(1, 4, 2, 9, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0);

    //           v  rs1 rs2 rd u1 u2 rw mr fl  st bb fa     fb     cnt
    vecs.push_back(mk(1, 1, 2, 5, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0)); // 0 add x5
    vecs.push_back(mk(1, 5, 1, 6, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0)); // 1 add x6=x5+x1
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0)); // 2 consumer in EX
    vecs.push_back(mk(1, 1, 2, 5, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0)); // 3 add x5
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0)); // 4 nop
    vecs.push_back(mk(1, 1, 5, 7, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0)); // 5 add x7=x1+x5
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0)); // 6 WB fwd on B
    vecs.push_back(mk(1, 1, 2, 5, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0)); // 7 add x5
    vecs.push_back(mk(1, 3, 4, 5, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0)); // 8 add x5 again
    vecs.push_back(mk(1, 5, 5, 8, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0)); // 9 add x8=x5+x5
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 0)); // 10 MEM beats WB
    vecs.push_back(mk(1, 1, 0, 4, 1, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0)); // 11 lw x4
    vecs.push_back(mk(1, 4, 2, 9, 1, 1, 1, 0, 0, 1, 1, 2'b00, 2'b00, 0)); // 12 load-use stall
    vecs.push_back(mk(1, 4, 2, 9, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1)); // 13 held, no stall
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 1)); // 14 WB fwd of load
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 1)); // 15 lw x0
    vecs.push_back(mk(1, 0, 0, 3, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1)); // 16 reads x0: no stall
    vecs.push_back(mk(1, 1, 3, 10, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1)); // 17 rs2=x3 unused
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 1)); // 18 no fwd on unused
    vecs.push_back(mk(1, 1, 0, 4, 1, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 1)); // 19 lw x4
    vecs.push_back(mk(1, 4, 2, 9, 1, 1, 1, 0, 1, 0, 1, 2'b00, 2'b00, 1)); // 20 hazard + flush
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 1)); // 21 after flush
    vecs.push_back(mk(1, 2, 0, 6, 1, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 1)); // 22 lw x6
    vecs.push_back(mk(1, 7, 6, 11, 1, 1, 1, 0, 0, 1, 1, 2'b00, 2'b00, 1)); // 23 rs2 load-use
    vecs.push_back(mk(1, 7, 6, 11, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2)); // 24 held
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2)); // 25 WB fwd on B

    // Reset held with a real, non-flushed instruction in ID.
    rst = 1'b1;
    drive1(mk(1, 1, 2, 3, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0));
    drive2(nop);
    #3;
    chk("rst_stall",  32'(bus.stall_o),     32'd0);
    chk("rst_bubble", 32'(bus.bubble_o),    32'd0);
    chk("rst_fwd_a",  32'(bus.fwd_a_o),     32'd0);
    chk("rst_fwd_b",  32'(bus.fwd_b_o),     32'd0);
    chk("rst_cnt",    32'(bus.stall_cnt_o), 32'd0);
    chk("rst_cnt2",   32'(bus2.stall_cnt_o), 32'd0);
    drive1(nop);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      drive1(vecs[i]);
      sbq.push_back(vecs[i]);
      @(negedge clk);
      e = sbq.pop_front();
      chk($sformatf("v%0d_stall", i),  32'(bus.stall_o),     32'(e.stall));
      chk($sformatf("v%0d_bubble", i), 32'(bus.bubble_o),    32'(e.bub));
      chk($sformatf("v%0d_fwd_a", i),  32'(bus.fwd_a_o),     32'(e.fa));
      chk($sformatf("v%0d_fwd_b", i),  32'(bus.fwd_b_o),     32'(e.fb));
      chk($sformatf("v%0d_cnt", i),    32'(bus.stall_cnt_o), 32'(e.cnt));
    end

    // Async reset during a stall, with x5 producers in MEM and WB.
    @(posedge clk); #1; drive1(mk(1, 1, 2, 5, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0));
    @(posedge clk); #1; drive1(mk(1, 3, 4, 5, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0));
    @(posedge clk); #1; drive1(lw4);
    @(posedge clk); #1; drive1(use4);
    @(negedge clk);
    chk("pre_rst_stall", 32'(bus.stall_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_stall",  32'(bus.stall_o),     32'd0);
    chk("mid_rst_bubble", 32'(bus.bubble_o),    32'd0);
    chk("mid_rst_fwd_a",  32'(bus.fwd_a_o),     32'd0);
    chk("mid_rst_fwd_b",  32'(bus.fwd_b_o),     32'd0);
    chk("mid_rst_cnt",    32'(bus.stall_cnt_o), 32'd0);
    drive1(mk(1, 5, 5, 1, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1; drive1(nop);
    @(negedge clk);
    chk("post_rst_fwd_a", 32'(bus.fwd_a_o), 32'd0);
    chk("post_rst_fwd_b", 32'(bus.fwd_b_o), 32'd0);

    // Saturation of a 2-bit stall counter over five load-use stalls.
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk); #1; drive2(lw4);
      @(posedge clk); #1; drive2(use4);
      @(negedge clk);
      chk($sformatf("sat%0d_stall", n), 32'(bus2.stall_o), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("sat%0d_cnt", n), 32'(bus2.stall_cnt_o), 32'((n > 3) ? 3 : n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Pipeline-control block for the 5-stage core.
- Tracks destination-register tags of in-flight instructions in its own shadow pipeline (EX, MEM, WB).
- Generates the 2-bit select for the two ALU-operand forwarding muxes.
- Detects load-use hazards, producing stall and bubble controls.
- Keeps a saturating stall-cycle counter for performance debug.
- Sits beside the ID stage; its outputs drive PC/IF-ID write enables, the ID/EX bubble insert, and the operand forwarding muxes in EX.

Parameters:
- REG_AW, 5, register-index width.
- CNT_W, 16, stall-counter width.

Ports:
- clk_i  in  1  core clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- id_valid_i  in  1  ID stage holds a real instruction.
- id_rs1_i  in  REG_AW  ID source register 1.
- id_rs2_i  in  REG_AW  ID source register 2.
- id_rd_i  in  REG_AW  ID destination register.
- id_uses_rs1_i  in  1  instruction reads rs1.
- id_uses_rs2_i  in  1  instruction reads rs2.
- id_regwrite_i  in  1  instruction writes rd.
- id_memread_i  in  1  instruction is a load.
- flush_i  in  1  squash the ID instruction (taken branch resolved in ID).
- stall_o  out  1  hold PC and IF/ID this cycle.
- bubble_o  out  1  load NOP into ID/EX this cycle.
- fwd_a_o  out  2  operand-A select for the instruction in EX.
- fwd_b_o  out  2  operand-B select for the instruction in EX.
- stall_cnt_o  out  CNT_W  count of stall cycles since reset.

Behaviour:
- Tag record per stage: rs1, rs2, rd, uses_rs1, uses_rs2, regwrite, memread. A bubble is the all-zero record.
- Reset (async, rst_i=1): all three stage records are bubbles; stall_cnt_o=0.
  - stall_o, bubble_o, fwd_a_o and fwd_b_o read 0 while reset is held, since their inputs are then bubbles or reset.
- Shadow pipeline advance, each rising edge:
  - WB <= MEM; MEM <= EX.
  - EX <= bubble if bubble_o=1, else the ID record.
- Load-use hazard:
  - hz = id_valid_i & !flush_i & EX.memread & EX.rd!=0 & ((id_uses_rs1_i & id_rs1_i==EX.rd) | (id_uses_rs2_i & id_rs2_i==EX.rd)).
  - stall_o = hz, combinational.
  - bubble_o = hz | flush_i | !id_valid_i.
  - A stall lasts exactly 1 cycle: the next cycle EX holds a bubble, so hz is 0.
- Flush takes priority over hazard: flush_i=1 forces stall_o=0 and bubble_o=1.
- Forwarding, per operand X in {A: rs1, B: rs2}:
  - 2'b10 if MEM.regwrite & MEM.rd!=0 & EX.uses_X & MEM.rd==EX.rsX (EX/MEM ALU result).
  - else 2'b01 if WB.regwrite & WB.rd!=0 & EX.uses_X & WB.rd==EX.rsX (MEM/WB writeback data).
  - else 2'b00 (ID/EX register-file operand).
  - MEM has priority over WB, i.e. the youngest producer wins.
  - 2'b11 is never driven.
- Fwd outputs depend only on internal flops: no input-to-output combinational path, so they are valid from the start of the cycle.
- x0 (rd=0) never forwards and never stalls.
- A load is never forwarded from MEM; the hazard stall guarantees this.
- stall_cnt_o increments on each edge where stall_o=1 and saturates at all-ones.

Decomposition:
- Shared package (core control package):
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - Packed stage-tag struct typedef and its bubble constant.
  - REG_AW default.
- Sub-module: fwd_sel_cmp, instantiated twice (A and B).
  - Inputs: EX source tag, uses flag, MEM and WB rd/regwrite.
  - Output: 2-bit select.

Test Plan:
1. EX/MEM forward: ID add x5; next cycle ID add x6 = x5 + x1 -> when the consumer is in EX, fwd_a_o=10, fwd_b_o=00.
2. WB forward and priority:
   - add x5, nop, add x7 = x1 + x5 -> fwd_b_o=01 in the consumer's EX cycle.
   - add x5, add x5, add x8 = x5 + x5 -> fwd_a_o = fwd_b_o = 10.
3. Load-use: lw x4 in EX, ID add x9 = x4 + x2 ->
   - Stall cycle: stall_o=1, bubble_o=1 for exactly 1 cycle.
   - Consumer's EX cycle (2 cycles later): fwd_a_o=01.
   - stall_cnt_o=1.
4. x0 and unused sources: lw x0 in EX with ID reading x0 -> stall_o=0, fwd=00. An instruction with id_uses_rs2_i=0 and matching rs2 bits -> fwd_b_o=00.
5. Flush during hazard: load-use condition plus flush_i=1 -> stall_o=0, bubble_o=1; following cycle fwd outputs 00 and the counter is unchanged.
6. Async reset mid-stream: assert rst_i between edges during a stall -> all outputs 0 immediately; after release, the first instruction sees fwd=00. Also force the counter to all-ones with CNT_W=2 -> it holds at 3.
